// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Kyber constants, zeta table and modular reduction helpers
`ifndef KYBER_POLY_WIDTH
`define KYBER_POLY_WIDTH 16
`endif

package kyber_pkg;
  localparam int W         = `KYBER_POLY_WIDTH;
  localparam int KYBER_Q   = 3329;
  localparam int QINV      = -3327;
  localparam int F_INV     = 1441;
  localparam int BARRETT_V = 20159;

  typedef logic signed [W-1:0] coeff_t;

  // Montgomery-domain zetas in bit-reversed order; invntt walks it from 127 down
  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  function automatic coeff_t barrett_reduce(input coeff_t a);
    logic signed [31:0] t;
    t = (BARRETT_V * a + 32'sd33554432) >>> 26;
    return W'(a - t * KYBER_Q);
  endfunction

  function automatic coeff_t montgomery_reduce(input logic signed [31:0] a);
    coeff_t t;
    t = W'($signed(a[15:0]) * QINV);
    return W'((a - t * KYBER_Q) >>> 16);
  endfunction

  function automatic coeff_t fqmul(input coeff_t a, input coeff_t b);
    return montgomery_reduce(32'(a) * 32'(b));
  endfunction
endpackage

// File: rtl/gs_butterfly.sv
// rtl/gs_butterfly.sv - combinational Gentleman-Sande butterfly for the inverse NTT
module gs_butterfly
  import kyber_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] zeta,
  output logic [W-1:0] s,
  output logic [W-1:0] d
);
  coeff_t sum, dif;

  // W-bit context gives the same wrap as the C int16 store of the int result
  assign sum = $signed(a) + $signed(b);
  assign dif = $signed(b) - $signed(a);
  assign s   = barrett_reduce(sum);
  assign d   = fqmul($signed(zeta), dif);
endmodule

// File: rtl/poly_invntt.sv
// rtl/poly_invntt.sv - sequential in-place Kyber inverse NTT, one butterfly per cycle
// INVNTT_SCALE_EN adds the SCALE pass multiplying every coefficient by f = 1441.
module poly_invntt
  import kyber_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic         wr_en,
  input  logic [7:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [7:0]   rd_addr,
  output logic [W-1:0] rd_data
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LAYER = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [2:0] layer;
  logic [7:0] idx;
  logic [6:0] k;
  logic [7:0] len, offset, j, jl;
  coeff_t     mem [256];
  coeff_t     zeta, bf_s, bf_d;

  assign busy    = (state == LAYER) || (state == SCALE);
  assign done    = (state == DONE);
  assign rd_data = mem[rd_addr];

  // j = group * 2*len + offset; the shift form never overflows 8 bits in layer 6
  assign len    = 8'd2 << layer;
  assign offset = idx & (len - 8'd1);
  assign j      = ((idx >> (layer + 3'd1)) << ({1'b0, layer} + 4'd2)) | offset;
  assign jl     = j + len;
  assign zeta   = W'(ZETAS[k]);

  gs_butterfly u_bf (
    .a    (mem[j]),
    .b    (mem[jl]),
    .zeta (zeta),
    .s    (bf_s),
    .d    (bf_d)
  );

  always_ff @(posedge clk) begin
    if (!busy && wr_en) begin
      mem[wr_addr] <= wr_data;
    end else if (state == LAYER) begin
      mem[j]  <= bf_s;
      mem[jl] <= bf_d;
    end
`ifdef INVNTT_SCALE_EN
    else if (state == SCALE) begin
      mem[idx] <= fqmul(mem[idx], W'(F_INV));
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      layer <= '0;
      idx   <= '0;
      k     <= 7'd127;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LAYER;
            layer <= '0;
            idx   <= '0;
            k     <= 7'd127;
          end
        end
        LAYER: begin
          if (offset == len - 8'd1) k <= k - 7'd1;
          if (idx == 8'd127) begin
            idx <= '0;
            if (layer == 3'd6) begin
              layer <= '0;
`ifdef INVNTT_SCALE_EN
              state <= SCALE;
`else
              state <= DONE;
`endif
            end else begin
              layer <= layer + 3'd1;
            end
          end else begin
            idx <= idx + 8'd1;
          end
        end
`ifdef INVNTT_SCALE_EN
        SCALE: begin
          idx <= idx + 8'd1;
          if (idx == 8'd255) state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_invntt.sv
// tb/tb_poly_invntt.sv - scoreboard bench for poly_invntt against a C-style invntt model
module tb_poly_invntt;
`ifdef INVNTT_SCALE_EN
  localparam int LAT = 1152;
`else
  localparam int LAT = 896;
`endif

  localparam int ZT [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  rd_addr = '0;
  logic        busy, done;
  logic [15:0] rd_data;
  logic        rd_vld = 1'b0;

  int checks = 0;
  int passes = 0;
  int exp_q[$];
  int vec[256];
  int gold[256];

  always #5 clk = ~clk;

  poly_invntt dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int s16(input int x);
    logic [15:0] b;
    b = x[15:0];
    return int'($signed(b));
  endfunction

  function automatic int m_mont(input int a);
    int t;
    t = s16(s16(a) * -3327);
    return (a - t * 3329) >>> 16;
  endfunction

  function automatic int m_barrett(input int a);
    int t;
    t = (20159 * a + (1 << 25)) >>> 26;
    return s16(a - t * 3329);
  endfunction

  task automatic model();
    int k, t, z;
    k = 127;
    gold = vec;
    for (int len = 2; len <= 128; len = len * 2) begin
      for (int st = 0; st < 256; st = st + 2 * len) begin
        z = ZT[k];
        k--;
        for (int jj = st; jj < st + len; jj++) begin
          t = gold[jj];
          gold[jj] = m_barrett(s16(t + gold[jj + len]));
          gold[jj + len] = m_mont(z * s16(gold[jj + len] - t));
        end
      end
    end
`ifdef INVNTT_SCALE_EN
    for (int jj = 0; jj < 256; jj++) gold[jj] = m_mont(gold[jj] * 1441);
`endif
  endtask

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check($sformatf("coeff[%0d]", rd_addr), int'($signed(rd_data)), exp_q.pop_front());
    end
  end

  task automatic load();
    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1;
      wr_addr = 8'(i);
      wr_data = 16'(vec[i]);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic readback();
    for (int i = 0; i < 256; i++) begin
      rd_addr = 8'(i);
      rd_vld = 1'b1;
      exp_q.push_back(gold[i]);
      @(posedge clk); #1;
    end
    rd_vld = 1'b0;
  endtask

  task automatic fill_rand(input int seed);
    int unsigned dummy;
    dummy = $urandom(seed);
    for (int i = 0; i < 256; i++) vec[i] = int'($urandom_range(6656)) - 3328;
  endtask

  task automatic run(input int inj, input int rst_at, output int done_at, output int busy_cnt);
    done_at = -1;
    busy_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < LAT + 20; c++) begin
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
          check("no_done_after_rst", int'(done), 0);
          @(posedge clk); #1;
        end
        return;
      end
      if (done) begin
        done_at = c;
        break;
      end
      if (busy) busy_cnt++;
      if (c == inj) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_addr = 8'd5;
        wr_data = 16'h7FFF;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic full(input string tag, input int inj, input bit hand_zero);
    int d, b;
    load();
    if (hand_zero) begin
      for (int i = 0; i < 256; i++) gold[i] = 0;
    end else begin
      model();
    end
    run(inj, -1, d, b);
    check({tag, "_done_at"}, d, LAT);
    check({tag, "_busy_cycles"}, b, LAT);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, int'(done), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
    readback();
  endtask

  initial begin
    int d, b;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);

    for (int i = 0; i < 256; i++) vec[i] = 0;
    full("zero", -1, 1'b1);

    vec[0] = 1;
    full("impulse", -1, 1'b0);

    for (int s = 1; s <= 3; s++) begin
      fill_rand(s);
      full($sformatf("rand%0d", s), -1, 1'b0);
    end

    fill_rand(7);
    full("disturb", 300, 1'b0);

    fill_rand(9);
    load();
    run(-1, 500, d, b);
    full("after_rst", -1, 1'b0);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
